// File: rtl/led_matrix_scanner.sv
// Multiplexed N x M LED matrix scanner with frame snapshot and generation strobe.
// Optional PWM brightness control when LED_MATRIX_SCANNER_BRIGHTNESS_EN is defined.
module led_matrix_scanner #(
  parameter int N              = 8,
  parameter int M              = 8,
  parameter int ROW_CYCLES     = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [N*M-1:0] cells,
`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
  input  logic [3:0]     duty,
`endif
  output logic [N-1:0]   rows,
  output logic [M-1:0]   cols,
  output logic           ena,
  output logic           frame_done
);

  localparam int CNT_MAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int ROW_W   = (N > 1) ? $clog2(N) : 1;
  localparam int GEN_W   = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(N - 1);
  localparam logic [GEN_W-1:0] GEN_LAST   = GEN_W'(FRAMES_PER_GEN - 1);

  typedef enum logic [1:0] {
    S_SNAPSHOT,
    S_ON,
    S_BLANK
  } state_t;

  state_t           state, state_n;
  logic [ROW_W-1:0] row_idx, row_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [GEN_W-1:0] frame_cnt, frame_cnt_n;
  logic [N*M-1:0]   snap, snap_n;
  logic [N-1:0]     rows_n;
  logic [M-1:0]     cols_n;
  logic             ena_n;
  logic             frame_done_n;

`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
  logic [3:0] pwm, pwm_n;
  assign pwm_n = pwm + 4'd1;
`endif

  // Sequencing: snapshot, then ON/BLANK per row.
  always_comb begin
    state_n = state;
    row_n   = row_idx;
    cnt_n   = cnt;
    snap_n  = snap;
    unique case (state)
      S_SNAPSHOT: begin
        snap_n  = cells;
        state_n = S_ON;
        row_n   = '0;
        cnt_n   = '0;
      end
      S_ON: begin
        if (cnt == ROW_LAST) begin
          state_n = S_BLANK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_n = '0;
          if (row_idx == ROW_MAX) begin
            row_n   = '0;
            state_n = S_SNAPSHOT;
          end else begin
            row_n   = row_idx + 1'b1;
            state_n = S_ON;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_SNAPSHOT;
        row_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // NOTE: outputs are decoded from the next-state values and registered, so
  // rows/cols/ena/frame_done line up exactly with the state they describe.
  always_comb begin
    rows_n       = '0;
    cols_n       = '1;
    ena_n        = 1'b0;
    frame_cnt_n  = frame_cnt;
    frame_done_n = (state_n == S_BLANK) && (row_n == ROW_MAX) && (cnt_n == BLANK_LAST);

    if (state_n == S_ON) begin
      rows_n[row_n] = 1'b1;
      cols_n        = ~snap_n[row_n*M +: M];
`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
      if (pwm_n > duty) cols_n = '1;
`endif
    end

    // run is sampled on the edge that opens the frame_done cycle.
    if (!run) begin
      frame_cnt_n = '0;
    end else if (frame_done_n) begin
      if (frame_cnt == GEN_LAST) begin
        frame_cnt_n = '0;
        ena_n       = 1'b1;
      end else begin
        frame_cnt_n = frame_cnt + 1'b1;
      end
    end
  end

  // NOTE: the snapshot register is cleared on reset like any other state; it is
  // a plain register, not a RAM, so the reset costs nothing structurally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_SNAPSHOT;
      row_idx    <= '0;
      cnt        <= '0;
      frame_cnt  <= '0;
      snap       <= '0;
      rows       <= '0;
      cols       <= '1;
      ena        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      row_idx    <= row_n;
      cnt        <= cnt_n;
      frame_cnt  <= frame_cnt_n;
      snap       <= snap_n;
      rows       <= rows_n;
      cols       <= cols_n;
      ena        <= ena_n;
      frame_done <= frame_done_n;
    end
  end

`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm <= '0;
    else     pwm <= pwm_n;
  end
`endif

endmodule
